fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle/pipelined RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, captures each returned word together with its PC into a 2-entry fetch buffer, and presents it to decode over a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch at the target.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, combinational imem address, 2-entry {pc, instr} buffer to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects set a sticky flag and halt fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imemAddr,
  input  logic [31:0] i_imemData,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_misaligned
);

  logic [31:0] pc_r;
  logic [31:0] pc_mem_r  [2];
  logic [31:0] ins_mem_r [2];
  logic [1:0]  count_r;
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic        valid_r;

  logic        pop_s;
  logic        push_s;
  logic        halt_s;
  logic [1:0]  count_next_s;
  logic [31:0] redirect_pc_s;

  assign redirect_pc_s = i_redirectPc & 32'hFFFF_FFFC;
  assign pop_s         = valid_r & i_ready;
  assign push_s        = ~i_redirect & ~halt_s & ((count_r != 2'd2) | pop_s);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_r;

  // Sticky misalignment flag: set by a misaligned redirect, cleared by reset or an aligned redirect.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      misaligned_r <= 1'b0;
    end else if (i_redirect) begin
      misaligned_r <= (i_redirectPc[1:0] != 2'b00);
    end
  end

  assign halt_s       = misaligned_r;
  assign o_misaligned = misaligned_r;
`else
  assign halt_s       = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // PC, buffer storage, pointers and occupancy; redirect flushes and outranks any push.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_r         <= RESET_PC;
      count_r      <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      valid_r      <= 1'b0;
      pc_mem_r[0]  <= 32'd0;
      pc_mem_r[1]  <= 32'd0;
      ins_mem_r[0] <= 32'd0;
      ins_mem_r[1] <= 32'd0;
    end else if (i_redirect) begin
      pc_r     <= redirect_pc_s;
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]  <= pc_r;
        ins_mem_r[wr_ptr_r] <= i_imemData;
        wr_ptr_r            <= ~wr_ptr_r;
        pc_r                <= pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
    end
  end

  assign o_imemAddr    = pc_r;
  assign o_valid       = valid_r;
  assign o_pc          = pc_mem_r[rd_ptr_r];
  assign o_instruction = ins_mem_r[rd_ptr_r];
  assign o_pcPlus4     = pc_mem_r[rd_ptr_r] + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model of the fetch buffer with random stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic        ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        valid;
  logic        mis;

  int errors = 0;
  int checks = 0;

  logic [63:0]  q[$];
  logic [31:0]  mpc;
  logic         mmis;
  logic [130:0] exp_vec;
  logic [130:0] obs_vec;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imemAddr(imem_addr), .i_imemData(imem_data),
    .i_redirect(redirect), .i_redirectPc(redirect_pc), .o_valid(valid), .i_ready(ready),
    .o_instruction(instr), .o_pc(pc), .o_pcPlus4(pc4), .o_misaligned(mis)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign imem_data = imem(imem_addr);
  assign obs_vec   = {valid, mis, imem_addr, valid ? {pc, instr, pc4} : 96'd0};

  task automatic update_exp();
    if (q.size() != 0)
      exp_vec = {1'b1, mmis, mpc, q[0][63:32], q[0][31:0], q[0][63:32] + 32'd4};
    else
      exp_vec = {1'b0, mmis, mpc, 96'd0};
  endtask

  task automatic do_reset();
    ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    q.delete(); mpc = 32'h0000_0000; mmis = 1'b0;
    update_exp();
  endtask

  // One clock: drive inputs, advance the model by the buffer rules, sample on the falling edge.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
    logic pop;
    ready = rdy; redirect = rd; redirect_pc = tgt;
    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (rd) begin
      q.delete();
      mpc = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      mmis = (tgt[1:0] != 2'b00);
`endif
    end else if (!mmis && q.size() < 2) begin
      q.push_back({mpc, imem(mpc)});
      mpc = mpc + 32'd4;
    end
    @(posedge clk); @(negedge clk);
    redirect = 1'b0;
    update_exp();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid !== 1'b0 || mis !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 ||
        instr !== 32'h0 || pc4 !== 32'h4) begin
      errors++;
      $display("FAIL reset valid=%b mis=%b addr=%h pc=%h instr=%h pc4=%h required 0 0 0 0 0 4",
               valid, mis, imem_addr, pc, instr, pc4);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'd0);
      checks++;
      if (obs_vec !== exp_vec || valid !== 1'b1 || pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream i=%0d got=%h pc=%h required=%h pc=%h", i, obs_vec, pc, exp_vec, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] nxt;
    do_reset();
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || imem_addr !== 32'h8 || pc !== 32'h0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL stall got addr=%h pc=%h valid=%b required addr=00000008 pc=00000000 valid=1",
               imem_addr, pc, valid);
    end
    nxt = 32'h0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pc !== nxt) begin
        errors++;
        $display("FAIL stall_release i=%0d got pc=%h required %h", i, pc, nxt);
      end
      nxt = nxt + 32'd4;
      step(1'b1, 1'b0, 32'd0);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0040);
    checks++;
    if (obs_vec !== exp_vec || valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect_n1 got valid=%b addr=%h required valid=0 addr=00000040", valid, imem_addr);
    end
    step(1'b1, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || valid !== 1'b1 || pc !== 32'h40) begin
      errors++;
      $display("FAIL redirect_n2 got valid=%b pc=%h required valid=1 pc=00000040", valid, pc);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0100);
    checks++;
    if (obs_vec !== exp_vec || valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_pop got valid=%b addr=%h required valid=0 addr=00000100", valid, imem_addr);
    end
    step(1'b1, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_pop_next got pc=%h required 00000100", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_first got pc=%h pc4=%h required fffffffc 00000000", pc, pc4);
    end
    step(1'b1, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || pc !== 32'h0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_second got pc=%h valid=%b required 00000000 1", pc, valid);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0042);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    checks++;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (obs_vec !== exp_vec || mis !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign got mis=%b valid=%b required mis=1 valid=0", mis, valid);
    end
`else
    if (obs_vec !== exp_vec || mis !== 1'b0 || pc !== 32'h44) begin
      errors++;
      $display("FAIL misalign got mis=%b pc=%h required mis=0 pc=00000044", mis, pc);
    end
`endif
    step(1'b1, 1'b1, 32'h0000_0080);
    step(1'b1, 1'b0, 32'd0);
    checks++;
    if (obs_vec !== exp_vec || mis !== 1'b0 || pc !== 32'h80 || valid !== 1'b1) begin
      errors++;
      $display("FAIL realign got mis=%b pc=%h valid=%b required 0 00000080 1", mis, pc, valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    do_reset();
    checks++;
    if (obs_vec !== exp_vec || valid !== 1'b0 || pc !== 32'h0 || pc4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_mid got valid=%b pc=%h pc4=%h required 0 00000000 00000004", valid, pc, pc4);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, tgt);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
